pick_sched: RTL and testbench
=============================

# pick_sched

Round-robin scheduler that produces the 3-bit `pick` command consumed by the token-transfer datapath, such as the `x1..x5` accumulator bank. The block arbitrates eight request lines, one per pick code, and registers the winner. It holds the winner stable under a valid/ready handshake and counts accepted commands. A compile-time option lets it generate pseudo-random picks when no request is pending, which drives free-running formal and simulation stimulus.

## Interface
- `W`, 3: pick code width; request vector is `1<<W` = 8 bits wide.
- `CW`, 16: width of the accepted-command counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request per pick code; bit k requests code k.
- `out_ready`  in  1  downstream accepts `pick` this cycle.
- `pick`  out  3  registered winning code.
- `pick_valid`  out  1  `pick` is offered.
- `grant_cnt`  out  CW  number of accepted picks; saturating.
- `idle`  out  1  scheduler is in IDLE.

## Operation
- The FSM has two states: IDLE (`pick_valid`=0, `idle`=1) and OFFER (`pick_valid`=1, `idle`=0).
- Round-robin pointer `ptr[2:0]`:
  - The winner is the first set bit of `req` searching `ptr, ptr+1, …` modulo 8.
  - The search wraps from 7 to 0.
- IDLE:
  - If `req`≠0, register the winner into `pick` and go to OFFER.
  - Otherwise, stay in IDLE. `pick` keeps its last value.
- OFFER with `out_ready`=0:
  - Hold `pick` and `pick_valid` stable.
  - Ignore `req` changes; an offer is never withdrawn or replaced.
- OFFER with `out_ready`=1 (accept):
  - Set `ptr` ← `pick`+1 mod 8.
  - Increment `grant_cnt`, saturating at all-ones.
  - Arbitrate `req` in the same cycle using the updated pointer, `pick`+1, computed combinationally.
  - If `req`≠0, load the new winner and stay in OFFER (back-to-back issue).
  - Otherwise, go to IDLE.
- `out_ready` is ignored in IDLE.
- Reset values: `pick`=0, `pick_valid`=0, `idle`=1, `grant_cnt`=0, `ptr`=0, and LFSR=8'h01 when compiled in.
  - Reset during OFFER drops the offer immediately and does not count it.

## Timing
- Latency: a request sampled at edge N produces `pick_valid`=1 after edge N. Minimum request-to-offer latency is one cycle.
- Throughput: one accepted pick per cycle while `req`≠0 and `out_ready`=1.
- `pick` changes only on:
  - the IDLE→OFFER edge;
  - an accepting edge;
  - reset.
- The counter updates on the accepting edge. `grant_cnt` reflects an accept one cycle after the handshake.
- All outputs are registered. There is no combinational path from `req` or `out_ready` to any output.

## Configuration
- `PICK_SCHED_LFSR_EN` defined: the block includes an 8-bit Fibonacci LFSR.
  - Polynomial x^8+x^6+x^5+x^4+1, seed 8'h01, shifting left with the feedback bit entering bit 0.
  - In IDLE with `req`=0, the block issues `pick`=LFSR[2:0] and goes to OFFER.
  - The LFSR advances once per such issue only.
  - With the same `req`=0 condition, an accept in OFFER also loads LFSR[2:0] and advances the LFSR.
  - Real requests always take priority over the LFSR.
  - `ptr` updates from every accepted pick, including LFSR picks.
  - LFSR picks count in `grant_cnt`.
  - `idle` is high only in the first cycle after reset.
- `PICK_SCHED_LFSR_EN` undefined: no LFSR logic is present, and `req`=0 leaves the block in IDLE with `pick_valid`=0.

## Test plan
- Reset: `rst`=1 with `req`=8'hFF → `pick`=0, `pick_valid`=0, `idle`=1, `grant_cnt`=0 while `rst` is high. The first offer after release is `pick`=0.
- Single request: `req`=8'h04, `out_ready`=1 from reset release.
  - One cycle later, `pick`=2 and `pick_valid`=1.
  - After the accept, `grant_cnt`=1.
  - With `req` dropped to 0 at the same edge, the block returns to IDLE.
- Full load: `req`=8'hFF, `out_ready`=1 held → `pick` sequence 0,1,2,…,7,0,1 on consecutive cycles. `grant_cnt` rises by 1 per cycle. `pick_valid` never drops.
- Stall and fairness: `req`=8'h81, `out_ready`=0 for 5 cycles → `pick`=0 held stable with `pick_valid`=1 and `grant_cnt` unchanged. Raise `out_ready` → accept, next `pick`=7, then 0.
- Saturation and mid-offer reset:
  - Drive 65 537 accepts → `grant_cnt`=16'hFFFF and stays there.
  - Then assert `rst` asynchronously while `pick`=5 is offered → `pick_valid` falls without a clock edge and `grant_cnt`=0.
  - After release, `req`=8'h21 yields `pick`=0.
- LFSR build: `PICK_SCHED_LFSR_EN` defined, `req`=0, `out_ready`=1 → first `pick`=3'b001 (seed), followed by successive LFSR[2:0] values, one per cycle. Asserting `req`=8'h40 → next issued `pick`=6.

Source files
------------

// File: rtl/pick_sched_if.sv
// -----------------------------------------------------------------------------
// pick_sched_if
// Bundles the scheduler's request/command handshake and status signals.
//   req        : one request line per pick code (1<<W bits)
//   out_ready  : downstream accepts the offered pick this cycle
//   pick       : registered winning code
//   pick_valid : pick is being offered
//   grant_cnt  : saturating count of accepted picks
//   idle       : scheduler is in its IDLE state
// Modports: master = scheduler side, slave = requester/consumer side.
// -----------------------------------------------------------------------------
interface pick_sched_if #(
   parameter int W  = 3,
   parameter int CW = 16
);
   logic [(1<<W)-1:0] req;
   logic              out_ready;
   logic [W-1:0]      pick;
   logic              pick_valid;
   logic [CW-1:0]     grant_cnt;
   logic              idle;

   modport master (
      input  req,
      input  out_ready,
      output pick,
      output pick_valid,
      output grant_cnt,
      output idle
   );

   modport slave (
      output req,
      output out_ready,
      input  pick,
      input  pick_valid,
      input  grant_cnt,
      input  idle
   );
endinterface

// File: rtl/pick_sched.sv
// -----------------------------------------------------------------------------
// pick_sched
// Round-robin scheduler producing a registered W-bit pick command under a
// valid/ready handshake, with a saturating count of accepted picks.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : pick_sched_if.master (req, out_ready in; pick, pick_valid,
//         grant_cnt, idle out)
// Build option: define PICK_SCHED_LFSR_EN to issue pseudo-random picks from
// an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01) whenever no request
// is pending. Without it, an empty request vector leaves the block in IDLE.
// -----------------------------------------------------------------------------
module pick_sched #(
   parameter int W  = 3,
   parameter int CW = 16
) (
   input  logic         clk,
   input  logic         rst,
   pick_sched_if.master bus
);
   localparam int N = 1 << W;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  ptr_q, ptr_d;
   logic [W-1:0]  pick_q, pick_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  ptr_inc_s;
   logic [W:0]    win_idle_s;
   logic [W:0]    win_acc_s;
   logic          pick_valid_s;
   logic          idle_s;
`ifdef PICK_SCHED_LFSR_EN
   logic [7:0]    lfsr_q, lfsr_d;
`endif

   // Returns {found, index}: first set bit of r searching base, base+1, ...
   // with wrap. Scanning downwards lets the lowest offset win.
   function automatic logic [W:0] rr_win(input logic [N-1:0] r, input logic [W-1:0] base);
      logic [W:0]   res;
      logic [W-1:0] idx;
      res = {(W+1){1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         idx = base + i[W-1:0];
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Saturating increment of the accept counter.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == {CW{1'b1}}) ? c : c + {{(CW-1){1'b0}}, 1'b1};
   endfunction

`ifdef PICK_SCHED_LFSR_EN
   // One left shift of the Fibonacci LFSR; taps 8,6,5,4 feed bit 0.
   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: pointer, offered pick, counter (and LFSR).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q  <= {W{1'b0}};
         pick_q <= {W{1'b0}};
         cnt_q  <= {CW{1'b0}};
`ifdef PICK_SCHED_LFSR_EN
         lfsr_q <= 8'h01;
`endif
      end else begin
         ptr_q  <= ptr_d;
         pick_q <= pick_d;
         cnt_q  <= cnt_d;
`ifdef PICK_SCHED_LFSR_EN
         lfsr_q <= lfsr_d;
`endif
      end
   end

   // Next-state and datapath update. An accept arbitrates with the already
   // advanced pointer (pick+1) so back-to-back issue stays fair.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      pick_d     = pick_q;
      cnt_d      = cnt_q;
`ifdef PICK_SCHED_LFSR_EN
      lfsr_d     = lfsr_q;
`endif
      ptr_inc_s  = pick_q + {{(W-1){1'b0}}, 1'b1};
      win_idle_s = rr_win(bus.req, ptr_q);
      win_acc_s  = rr_win(bus.req, ptr_inc_s);
      case (state_q)
         ST_IDLE: begin
            if (win_idle_s[W]) begin
               pick_d  = win_idle_s[W-1:0];
               state_d = ST_OFFER;
            end else begin
`ifdef PICK_SCHED_LFSR_EN
               pick_d  = lfsr_q[W-1:0];
               lfsr_d  = lfsr_next(lfsr_q);
               state_d = ST_OFFER;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         ST_OFFER: begin
            if (bus.out_ready) begin
               ptr_d = ptr_inc_s;
               cnt_d = sat_inc(cnt_q);
               if (win_acc_s[W]) begin
                  pick_d  = win_acc_s[W-1:0];
                  state_d = ST_OFFER;
               end else begin
`ifdef PICK_SCHED_LFSR_EN
                  pick_d  = lfsr_q[W-1:0];
                  lfsr_d  = lfsr_next(lfsr_q);
                  state_d = ST_OFFER;
`else
                  state_d = ST_IDLE;
`endif
               end
            end else begin
               // Offer is held: never withdrawn or replaced while stalled.
               state_d = ST_OFFER;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the state register only.
   always_comb begin
      pick_valid_s = 1'b0;
      idle_s       = 1'b1;
      case (state_q)
         ST_IDLE: begin
            pick_valid_s = 1'b0;
            idle_s       = 1'b1;
         end
         ST_OFFER: begin
            pick_valid_s = 1'b1;
            idle_s       = 1'b0;
         end
         default: begin
            pick_valid_s = 1'b0;
            idle_s       = 1'b1;
         end
      endcase
   end

   assign bus.pick       = pick_q;
   assign bus.pick_valid = pick_valid_s;
   assign bus.grant_cnt  = cnt_q;
   assign bus.idle       = idle_s;

endmodule

// File: tb/tb_pick_sched.sv
// -----------------------------------------------------------------------------
// tb_pick_sched
// Directed and randomized stimulus for pick_sched, checked every cycle against
// a behavioural model of the scheduling rules (offer flag, round-robin pointer,
// saturating counter, optional LFSR) using immediate assertions.
// -----------------------------------------------------------------------------
module tb_pick_sched;
   logic clk;
   logic rst;

   pick_sched_if #(.W(3), .CW(16)) bus ();

   pick_sched #(.W(3), .CW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Behavioural model state
   bit m_offer;
   int m_pick;
   int m_ptr;
   int m_cnt;
   int m_lfsr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   // First requesting code at or after base, wrapping modulo 8; -1 if none.
   function automatic int rr_ref(input logic [7:0] r, input int base);
      for (int k = 0; k < 8; k++) begin
         if (r[(base + k) % 8]) return (base + k) % 8;
      end
      return -1;
   endfunction

   function automatic int lfsr_adv(input int l);
      int fb;
      fb = $countones(l & 32'hB8) % 2;
      return ((l << 1) | fb) & 32'hFF;
   endfunction

   task automatic model_reset();
      m_offer = 1'b0;
      m_pick  = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_lfsr  = 1;
   endtask

   // Apply one clock edge's worth of scheduling rules to the model.
   task automatic model_step(input logic [7:0] r, input bit rdy);
      int w;
      if (!m_offer) begin
         w = rr_ref(r, m_ptr);
         if (w >= 0) begin
            m_pick = w; m_offer = 1'b1;
         end else begin
`ifdef PICK_SCHED_LFSR_EN
            m_pick = m_lfsr % 8; m_lfsr = lfsr_adv(m_lfsr); m_offer = 1'b1;
`endif
         end
      end else if (rdy) begin
         m_ptr = (m_pick + 1) % 8;
         if (m_cnt != 65535) m_cnt = m_cnt + 1;
         w = rr_ref(r, m_ptr);
         if (w >= 0) begin
            m_pick = w;
         end else begin
`ifdef PICK_SCHED_LFSR_EN
            m_pick = m_lfsr % 8; m_lfsr = lfsr_adv(m_lfsr);
`else
            m_offer = 1'b0;
`endif
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pick"},       32'(bus.pick),       32'(m_pick));
      chk({tag, ".pick_valid"}, 32'(bus.pick_valid), 32'(m_offer));
      chk({tag, ".idle"},       32'(bus.idle),       32'(!m_offer));
      chk({tag, ".grant_cnt"},  32'(bus.grant_cnt),  32'(m_cnt));
   endtask

   // Called at a negedge: drive inputs, clock once, compare at next negedge.
   task automatic cycle(input logic [7:0] r, input bit rdy, input string tag);
      bus.req       = r;
      bus.out_ready = rdy;
      model_step(r, rdy);
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset(input logic [7:0] r);
      rst           = 1'b1;
      bus.req       = r;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      check_all("reset");
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.req       = 8'hFF;
      bus.out_ready = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset with all requests pending
      do_reset(8'hFF);
      chk("reset_pick_valid", 32'(bus.pick_valid), 32'd0);
      chk("reset_idle", 32'(bus.idle), 32'd1);
      cycle(8'hFF, 1'b0, "first_offer");
      chk("first_offer_pick", 32'(bus.pick), 32'd0);

      // Single request, dropped at the accepting edge
      do_reset(8'h00);
      cycle(8'h04, 1'b1, "single");
      chk("single_pick", 32'(bus.pick), 32'd2);
      chk("single_valid", 32'(bus.pick_valid), 32'd1);
      cycle(8'h00, 1'b1, "single_acc");
      chk("single_cnt", 32'(bus.grant_cnt), 32'd1);
`ifndef PICK_SCHED_LFSR_EN
      chk("single_idle", 32'(bus.idle), 32'd1);
`endif

      // Full load: 0..7,0,1 back to back
      do_reset(8'h00);
      for (int i = 0; i < 10; i++) begin
         cycle(8'hFF, 1'b1, "full");
         chk("full_seq", 32'(bus.pick), 32'(i % 8));
      end

      // Stall then fairness between codes 0 and 7
      do_reset(8'h00);
      for (int i = 0; i < 5; i++) cycle(8'h81, 1'b0, "stall");
      chk("stall_pick", 32'(bus.pick), 32'd0);
      cycle(8'h81, 1'b1, "fair1");
      chk("fair1_pick", 32'(bus.pick), 32'd7);
      cycle(8'h81, 1'b1, "fair2");
      chk("fair2_pick", 32'(bus.pick), 32'd0);

      // Randomized traffic
      do_reset(8'h00);
      for (int i = 0; i < 400; i++) begin
         logic [7:0] r;
         r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = 8'h00;
         cycle(r, 1'($urandom_range(0, 1)), "rand");
      end

      // Counter saturation
      do_reset(8'h00);
      cycle(8'hFF, 1'b1, "sat_start");
      for (int i = 0; i < 65537; i++) cycle(8'hFF, 1'b1, "sat");
      chk("sat_cnt", 32'(bus.grant_cnt), 32'hFFFF);
      for (int i = 0; i < 4; i++) cycle(8'hFF, 1'b1, "sat_hold");
      chk("sat_cnt_hold", 32'(bus.grant_cnt), 32'hFFFF);
      chk("sat_pick5", 32'(bus.pick), 32'd5);
      cycle(8'hFF, 1'b0, "sat_stall");

      // Asynchronous reset mid-offer, no clock edge involved
      #2;
      rst = 1'b1;
      #1;
      chk("async_valid", 32'(bus.pick_valid), 32'd0);
      chk("async_cnt", 32'(bus.grant_cnt), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(8'h21, 1'b0, "post_rst");
      chk("post_rst_pick", 32'(bus.pick), 32'd0);

`ifdef PICK_SCHED_LFSR_EN
      // Free-running LFSR picks: 1,2,4,0,1 from seed 8'h01
      do_reset(8'h00);
      cycle(8'h00, 1'b1, "lfsr0");
      chk("lfsr_seed", 32'(bus.pick), 32'd1);
      cycle(8'h00, 1'b1, "lfsr1");
      chk("lfsr_1", 32'(bus.pick), 32'd2);
      cycle(8'h00, 1'b1, "lfsr2");
      chk("lfsr_2", 32'(bus.pick), 32'd4);
      cycle(8'h00, 1'b1, "lfsr3");
      chk("lfsr_3", 32'(bus.pick), 32'd0);
      cycle(8'h40, 1'b1, "lfsr_req");
      chk("lfsr_req_pick", 32'(bus.pick), 32'd6);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
